// File: rtl/updown_counter_mod.sv
// Parametrised synchronous up/down modulo counter with load, enable,
// wrap/saturate mode, combinational terminal count and a registered wrap pulse.
module updown_counter_mod #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = (1 << WIDTH) - 1,
   parameter int RST_VAL = MAX_VAL
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             En,
   input  logic             Up,
   input  logic             Sat,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Wrapped
);

   localparam logic [WIDTH-1:0] max_q  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] rst_q  = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] zero_q = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] one_q  = WIDTH'(1);

   logic [WIDTH-1:0] q_r;
   logic             wrap_r;
   logic [WIDTH-1:0] q_nxt_s;
   logic             wrap_nxt_s;
   logic             at_end_s;

   // End of the count range in the currently selected direction
   always_comb begin
      at_end_s = 1'b0;
      if (Up) begin
         at_end_s = (q_r == max_q);
      end else begin
         at_end_s = (q_r == zero_q);
      end
   end

   // Next count and wrap pulse; Load outranks En
   always_comb begin
      q_nxt_s    = q_r;
      wrap_nxt_s = 1'b0;
      case ({Load, En})
         2'b10, 2'b11: begin
            // Out-of-range load data clamps so unused codes stay unreachable
            if (D > max_q) begin
               q_nxt_s = max_q;
            end else begin
               q_nxt_s = D;
            end
         end
         2'b01: begin
            if (!at_end_s) begin
               q_nxt_s = Up ? (q_r + one_q) : (q_r - one_q);
            end else if (Sat) begin
               q_nxt_s = q_r;
            end else begin
               q_nxt_s    = Up ? zero_q : max_q;
               wrap_nxt_s = 1'b1;
            end
         end
         2'b00: begin
            q_nxt_s = q_r;
         end
         default: begin
            q_nxt_s    = q_r;
            wrap_nxt_s = 1'b0;
         end
      endcase
   end

   // Count and wrap-pulse registers
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         q_r    <= rst_q;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt_s;
         wrap_r <= wrap_nxt_s;
      end
   end

   assign Q       = q_r;
   assign Wrapped = wrap_r;
   assign TC      = En & at_end_s;

endmodule
